// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks: receiver state encoding,
// parity sense constants and the parity check used at the parity sample point.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 9;

  // High when the data bits plus the received parity bit do not match the
  // selected sense; narrower words are zero-extended, which leaves the XOR intact.
  function automatic logic parity_mismatch(input logic [MAX_DATA_BITS-1:0] data,
                                           input logic par_bit,
                                           input logic sense);
    return ((^data) ^ par_bit) != sense;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer that resets to 1, matching the idle level of a UART
// line, so reset never fakes a start or CTS edge.
module uart_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receive deserializer driven by an oversampling tick; delivers each frame
// through a valid/ready output register with per-word parity and framing flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  // Handshake: rx_data and the error flags are meaningful while rx_valid=1;
  // a word transfers on any clock edge where rx_valid && rx_ready, and rx_valid
  // stays high until that happens. overrun_err is an unhandshaked one-cycle pulse.

  rx_state_e           state;
  logic                rx_s;
  logic [OS_W-1:0]     os_cnt;
  logic [BC_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                perr;
  logic                sample;
  logic                out_free;

  uart_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign sample   = os_tick && (os_cnt == OS_LAST);
  assign out_free = !rx_valid || rx_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      perr        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      // A delivery later in this block overrides the clear.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (os_tick && !rx_s) begin
            state  <= START;
            os_cnt <= '0;
          end
        end

        START: begin
          if (os_tick) begin
            if (os_cnt == OS_HALF) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              perr    <= 1'b0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (os_tick) begin
            if (sample) begin
              os_cnt  <= '0;
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BC_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (os_tick) begin
            if (sample) begin
              os_cnt <= '0;
              perr   <= parity_mismatch(MAX_DATA_BITS'(shreg), rx_s, PAR_SENSE);
              state  <= STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (os_tick) begin
            if (sample) begin
              os_cnt <= '0;
              if (out_free) begin
                rx_data    <= shreg;
                parity_err <= perr;
                frame_err  <= !rx_s;
                rx_valid   <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
              // A low stop bit is treated as a possible break; wait for idle.
              state <= rx_s ? IDLE : WAIT_HIGH;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        WAIT_HIGH: begin
          if (os_tick && rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 receiver and an 8E1 receiver share clock, reset
// and a divide-by-4 oversample tick; each has its own line and ready input.
module tb_uart_rx;

  localparam int BIT_CLK = 64;  // 16 ticks x 4 clk

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       os_tick = 1'b0;
  int         tick_div = 0;
  logic       rx_line [2];
  logic       rdy [2];
  logic [7:0] rx_data_o [2];
  logic       valid_o [2];
  logic       perr_o [2];
  logic       ferr_o [2];
  logic       ovr_o [2];
  logic       busy_o [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  int         acc_cnt [2];
  int         ovr_cnt [2];
  int         busy_cyc [2];
  logic [7:0] last_data [2];
  logic       last_perr [2];
  logic       last_ferr [2];

  // Clock / reset / tick generation
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tick_div = (tick_div + 1) % 4;
    os_tick  = (tick_div == 3);
  end

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(16)) dut_8n1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .os_tick     (os_tick),
    .rx          (rx_line[0]),
    .rx_ready    (rdy[0]),
    .rx_data     (rx_data_o[0]),
    .rx_valid    (valid_o[0]),
    .parity_err  (perr_o[0]),
    .frame_err   (ferr_o[0]),
    .overrun_err (ovr_o[0]),
    .busy        (busy_o[0])
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(16)) dut_8e1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .os_tick     (os_tick),
    .rx          (rx_line[1]),
    .rx_ready    (rdy[1]),
    .rx_data     (rx_data_o[1]),
    .rx_valid    (valid_o[1]),
    .parity_err  (perr_o[1]),
    .frame_err   (ferr_o[1]),
    .overrun_err (ovr_o[1]),
    .busy        (busy_o[1])
  );

  // Output monitor: records accepted words, overrun pulses and busy cycles
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (valid_o[i] && rdy[i]) begin
          acc_cnt[i]++;
          last_data[i] = rx_data_o[i];
          last_perr[i] = perr_o[i];
          last_ferr[i] = ferr_o[i];
        end
        if (ovr_o[i])  ovr_cnt[i]++;
        if (busy_o[i]) busy_cyc[i]++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after a clock edge at which the DUTs saw os_tick=1.
  task automatic wait_tick();
    do @(posedge clk); while (!os_tick);
  endtask

  // Drives one frame starting right after a tick edge T. If ready_at >= 0,
  // rdy[sel] is high for exactly the cycle ending at edge T+ready_at+1.
  task automatic send_frame(input int sel, input logic [7:0] data, input bit has_par,
                            input bit par_bit, input bit stop_bit, input int ready_at);
    logic [11:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = data[i];
    n = 9;
    if (has_par) begin
      f[n] = par_bit;
      n++;
    end
    f[n] = stop_bit;
    n++;
    wait_tick();
    for (int c = 0; c < n * BIT_CLK; c++) begin
      #1;
      rx_line[sel] = f[c / BIT_CLK];
      if (ready_at >= 0) begin
        if (c == ready_at) rdy[sel] = 1'b1;
        else if (c == ready_at + 1) rdy[sel] = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    rx_line[sel] = 1'b1;
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    bit         par_bit;
    bit         stop_bit;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int a0;
    int o0;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[5] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[8] = '{1, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};

    for (int i = 0; i < 2; i++) begin
      rx_line[i] = 1'b1;
      rdy[i] = 1'b0;
      acc_cnt[i] = 0;
      ovr_cnt[i] = 0;
      busy_cyc[i] = 0;
      last_data[i] = '0;
      last_perr[i] = 1'b0;
      last_ferr[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_data", 32'(rx_data_o[i]), 32'h0);
      check("rst_valid", 32'(valid_o[i]), 32'h0);
      check("rst_perr", 32'(perr_o[i]), 32'h0);
      check("rst_ferr", 32'(ferr_o[i]), 32'h0);
      check("rst_ovr", 32'(ovr_o[i]), 32'h0);
      check("rst_busy", 32'(busy_o[i]), 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2 * BIT_CLK);

    // Table-driven frames with the consumer always ready
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    foreach (vecs[k]) begin
      a0 = acc_cnt[vecs[k].sel];
      send_frame(vecs[k].sel, vecs[k].data, vecs[k].sel == 1, vecs[k].par_bit, vecs[k].stop_bit, -1);
      idle(2 * BIT_CLK);
      @(negedge clk);
      check($sformatf("vec%0d_count", k), 32'(acc_cnt[vecs[k].sel] - a0), 32'd1);
      check($sformatf("vec%0d_data", k), 32'(last_data[vecs[k].sel]), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d_perr", k), 32'(last_perr[vecs[k].sel]), 32'(vecs[k].exp_perr));
      check($sformatf("vec%0d_ferr", k), 32'(last_ferr[vecs[k].sel]), 32'(vecs[k].exp_ferr));
      check($sformatf("vec%0d_busy", k), 32'(busy_o[vecs[k].sel]), 32'h0);
    end

    // Glitch: 3 ticks low aborts in START
    a0 = acc_cnt[0];
    busy_cyc[0] = 0;
    wait_tick();
    #1;
    rx_line[0] = 1'b0;
    idle(12);
    rx_line[0] = 1'b1;
    idle(200);
    @(negedge clk);
    check("glitch_no_word", 32'(acc_cnt[0] - a0), 32'd0);
    check("glitch_busy_seen", 32'(busy_cyc[0] > 0), 32'd1);
    check("glitch_busy_bound", 32'(busy_cyc[0] <= 32), 32'd1);
    check("glitch_busy_end", 32'(busy_o[0]), 32'h0);

    // Break: line low for three frame times
    a0 = acc_cnt[0];
    wait_tick();
    #1;
    rx_line[0] = 1'b0;
    idle(30 * BIT_CLK);
    @(negedge clk);
    check("break_busy_held", 32'(busy_o[0]), 32'h1);
    check("break_one_word", 32'(acc_cnt[0] - a0), 32'd1);
    check("break_data", 32'(last_data[0]), 32'h00);
    check("break_ferr", 32'(last_ferr[0]), 32'h1);
    @(posedge clk);
    #1;
    rx_line[0] = 1'b1;
    idle(4 * BIT_CLK);
    @(negedge clk);
    check("break_release_busy", 32'(busy_o[0]), 32'h0);
    check("break_release_count", 32'(acc_cnt[0] - a0), 32'd1);

    // Overrun: two frames with no consumer
    @(posedge clk);
    #1;
    rdy[0] = 1'b0;
    a0 = acc_cnt[0];
    o0 = ovr_cnt[0];
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
    idle(2 * BIT_CLK);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
    idle(2 * BIT_CLK);
    @(negedge clk);
    check("ovr_valid", 32'(valid_o[0]), 32'h1);
    check("ovr_data_held", 32'(rx_data_o[0]), 32'h11);
    check("ovr_pulses", 32'(ovr_cnt[0] - o0), 32'd1);
    check("ovr_no_accept", 32'(acc_cnt[0] - a0), 32'd0);
    @(posedge clk);
    #1;
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    rdy[0] = 1'b0;
    @(negedge clk);
    check("ovr_accept", 32'(acc_cnt[0] - a0), 32'd1);
    check("ovr_accept_data", 32'(last_data[0]), 32'h11);
    check("ovr_valid_clear", 32'(valid_o[0]), 32'h0);

    // Back-to-back: ready only in the cycle of the second stop sample (edge T+612)
    @(posedge clk);
    #1;
    a0 = acc_cnt[0];
    o0 = ovr_cnt[0];
    send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1, -1);
    idle(2 * BIT_CLK);
    send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1, 611);
    idle(BIT_CLK);
    @(negedge clk);
    check("b2b_accept", 32'(acc_cnt[0] - a0), 32'd1);
    check("b2b_accept_data", 32'(last_data[0]), 32'h33);
    check("b2b_valid", 32'(valid_o[0]), 32'h1);
    check("b2b_data", 32'(rx_data_o[0]), 32'h44);
    check("b2b_no_ovr", 32'(ovr_cnt[0] - o0), 32'd0);

    // Reset in the middle of the data bits, then a clean frame
    @(posedge clk);
    wait_tick();
    #1;
    rx_line[0] = 1'b0;
    idle(BIT_CLK);
    rx_line[0] = 1'b1;
    idle(100);
    rst_n = 1'b0;
    rx_line[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", 32'(valid_o[0]), 32'h0);
    check("mid_rst_data", 32'(rx_data_o[0]), 32'h0);
    check("mid_rst_busy", 32'(busy_o[0]), 32'h0);
    check("mid_rst_ferr", 32'(ferr_o[0]), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2 * BIT_CLK);
    @(negedge clk);
    check("post_rst_no_word", 32'(valid_o[0]), 32'h0);
    @(posedge clk);
    #1;
    rdy[0] = 1'b1;
    a0 = acc_cnt[0];
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
    idle(2 * BIT_CLK);
    @(negedge clk);
    check("post_rst_count", 32'(acc_cnt[0] - a0), 32'd1);
    check("post_rst_data", 32'(last_data[0]), 32'h5A);
    check("post_rst_ferr", 32'(last_ferr[0]), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
